// File: rtl/axi_ram_slave_pkg.sv
// rtl/axi_ram_slave_pkg.sv - shared bus widths, burst/resp codes and FSM encodings for axi_ram_slave
package axi_ram_slave_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_ID_W   = 4;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;
  localparam int AXI_LEN_W  = 8;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_DATA = 2'b01,
    W_RESP = 2'b10
  } wr_state_t;

  // WRAP is handled like INCR; only FIXED holds the word index.
  function automatic logic burst_advances(input logic [1:0] burst);
    return burst != BURST_FIXED;
  endfunction

endpackage

// File: rtl/axi_ram_array.sv
// rtl/axi_ram_array.sv - 32-bit word RAM, async read port, byte-enabled synchronous write port
module axi_ram_array #(
  parameter int ADDR_W    = 12,
  parameter int INIT_ZERO = 1
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [3:0]        wbe,
  input  logic [31:0]       wdata
);

  localparam int DEPTH = 1 << ADDR_W;

  // Contents are only defined at elaboration; reset never touches them.
  logic [31:0] mem [DEPTH] = '{default: ((INIT_ZERO != 0) ? 32'h0 : 32'hx)};

  assign rdata = mem[raddr];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (wbe[i]) begin
          mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/axi_ram_slave.sv
// rtl/axi_ram_slave.sv - AXI3-style single-outstanding RAM slave with independent read and write FSMs
module axi_ram_slave
  import axi_ram_slave_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int INIT_ZERO = 1
) (
  input  logic        clk,
  input  logic        reset,

  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,

  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,

  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,

  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,

  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  rd_state_t r_state, r_state_nxt;
  logic [3:0]        r_id;
  logic [ADDR_W-1:0] r_idx;
  logic [7:0]        r_len;
  logic [7:0]        r_cnt;
  logic [1:0]        r_burst;

  wr_state_t w_state, w_state_nxt;
  logic [3:0]        w_id;
  logic [ADDR_W-1:0] w_idx;
  logic [7:0]        w_len;
  logic [7:0]        w_cnt;
  logic [1:0]        w_burst;

  logic [31:0] arr_rdata;
  logic        ar_hs, r_hs, aw_hs, w_hs, w_last_beat;

  assign ar_hs       = arvalid & arready;
  assign r_hs        = rvalid & rready;
  assign aw_hs       = awvalid & awready;
  assign w_hs        = wvalid & wready;
  assign w_last_beat = (w_cnt == w_len);

  // Sizes, lock/cache/prot, wid and wlast carry no meaning for this slave.
  logic unused_inputs;
  assign unused_inputs = ^{araddr[31:ADDR_W+2], araddr[1:0], awaddr[31:ADDR_W+2],
                           awaddr[1:0], arsize, awsize, arlock, arcache, arprot,
                           awlock, awcache, awprot, wid, wlast};

  axi_ram_array #(
    .ADDR_W    (ADDR_W),
    .INIT_ZERO (INIT_ZERO)
  ) u_array (
    .clk   (clk),
    .raddr (r_idx),
    .rdata (arr_rdata),
    .we    (w_hs),
    .waddr (w_idx),
    .wbe   (wstrb),
    .wdata (wdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= R_IDLE;
    end else begin
      r_state <= r_state_nxt;
    end
  end

  always_comb begin
    r_state_nxt = r_state;
    arready     = 1'b0;
    rvalid      = 1'b0;
    rlast       = 1'b0;
    case (r_state)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) begin
          r_state_nxt = R_DATA;
        end
      end
      R_DATA: begin
        rvalid = 1'b1;
        rlast  = (r_cnt == r_len);
        if (rready && rlast) begin
          r_state_nxt = R_IDLE;
        end
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_id    <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_burst <= BURST_FIXED;
    end else if (ar_hs) begin
      r_id    <= arid;
      r_idx   <= araddr[ADDR_W+1:2];
      r_len   <= arlen;
      r_cnt   <= '0;
      r_burst <= arburst;
    end else if (r_hs && !rlast) begin
      r_cnt <= r_cnt + 8'd1;
      if (burst_advances(r_burst)) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  // Async read off the held index keeps rdata stable across stalls.
  assign rid   = r_id;
  assign rresp = RESP_OKAY;
  assign rdata = (r_state == R_DATA) ? arr_rdata : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state <= W_IDLE;
    end else begin
      w_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = w_state;
    awready     = 1'b0;
    wready      = 1'b0;
    bvalid      = 1'b0;
    case (w_state)
      W_IDLE: begin
        awready = 1'b1;
        if (awvalid) begin
          w_state_nxt = W_DATA;
        end
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid && w_last_beat) begin
          w_state_nxt = W_RESP;
        end
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) begin
          w_state_nxt = W_IDLE;
        end
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_id    <= '0;
      w_idx   <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_burst <= BURST_FIXED;
    end else if (aw_hs) begin
      w_id    <= awid;
      w_idx   <= awaddr[ADDR_W+1:2];
      w_len   <= awlen;
      w_cnt   <= '0;
      w_burst <= awburst;
    end else if (w_hs && !w_last_beat) begin
      w_cnt <= w_cnt + 8'd1;
      if (burst_advances(w_burst)) begin
        w_idx <= w_idx + 1'b1;
      end
    end
  end

  assign bid   = w_id;
  assign bresp = RESP_OKAY;

endmodule

// File: tb/tb_axi_ram_slave.sv
// tb/tb_axi_ram_slave.sv - scoreboard bench for axi_ram_slave against a word-array reference model
module tb_axi_ram_slave;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 1 << ADDR_W;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  arid, awid, wid;
  logic [31:0] araddr, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, awvalid, wvalid, wlast, rready, bready;
  logic        arready, awready, wready, rvalid, rlast, bvalid;
  logic [3:0]  rid, bid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;

  always #5 clk = ~clk;

  axi_ram_slave #(.ADDR_W(ADDR_W), .INIT_ZERO(1)) dut (
    .clk(clk), .reset(reset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  id;
    logic        last;
  } rexp_t;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] ref_mem [DEPTH];
  rexp_t       rq[$];
  logic [3:0]  bq[$];
  int          rready_mode = 0;
  logic [31:0] wbuf_data [256];
  logic [3:0]  wbuf_strb [256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_write(input logic [ADDR_W-1:0] i, input logic [31:0] d,
                                      input logic [3:0] s);
    for (int k = 0; k < 4; k++) begin
      if (s[k]) ref_mem[i][8*k +: 8] = d[8*k +: 8];
    end
  endfunction

  initial begin
    int k;
    k = 0;
    rready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rready_mode)
        0:       rready = 1'b1;
        1:       rready = (k % 3 == 0);
        default: rready = 1'($urandom_range(0, 1));
      endcase
      k++;
    end
  end

  // Monitor: pops the scoreboard on each R/B handshake and checks stall stability.
  initial begin
    rexp_t       e;
    logic [3:0]  eb;
    logic        stall_seen;
    logic [31:0] stall_data;
    logic [3:0]  stall_id;
    logic        stall_last;
    stall_seen = 1'b0;
    stall_data = '0;
    stall_id   = '0;
    stall_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && rvalid) begin
        if (stall_seen) begin
          check("r_hold_data", rdata, stall_data);
          check("r_hold_id", {28'h0, rid}, {28'h0, stall_id});
          check("r_hold_last", {31'h0, rlast}, {31'h0, stall_last});
        end
        if (rready) begin
          stall_seen = 1'b0;
          if (rq.size() == 0) begin
            check("r_unexpected_beat", 32'h1, 32'h0);
          end else begin
            e = rq.pop_front();
            check("r_data", rdata, e.data);
            check("r_id", {28'h0, rid}, {28'h0, e.id});
            check("r_last", {31'h0, rlast}, {31'h0, e.last});
            check("r_resp", {30'h0, rresp}, 32'h0);
          end
        end else begin
          stall_seen = 1'b1;
          stall_data = rdata;
          stall_id   = rid;
          stall_last = rlast;
        end
      end else begin
        stall_seen = 1'b0;
      end
      if (!reset && bvalid && bready) begin
        if (bq.size() == 0) begin
          check("b_unexpected", 32'h1, 32'h0);
        end else begin
          eb = bq.pop_front();
          check("b_id", {28'h0, bid}, {28'h0, eb});
          check("b_resp", {30'h0, bresp}, 32'h0);
        end
      end
    end
  end

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
    logic [ADDR_W-1:0] idx;
    rexp_t             e;
    int                n;
    idx = addr[ADDR_W+1:2];
    for (int b = 0; b <= int'(len); b++) begin
      e.data = ref_mem[idx];
      e.id   = id;
      e.last = (b == int'(len));
      rq.push_back(e);
      if (burst != 2'b00) idx = idx + 1'b1;
    end
    arid = id; araddr = addr; arlen = len; arburst = burst; arsize = 3'($urandom);
    arvalid = 1'b1;
    @(negedge clk);
    check("arready_idle", {31'h0, arready}, 32'h1);
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    araddr  = $urandom;
    @(negedge clk);
    check("rvalid_latency", {31'h0, rvalid}, 32'h1);
    n = 0;
    while (rq.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (rq.size() != 0) begin
      check("r_timeout", 32'h0, 32'h1);
      rq.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int bhold, input bit early_w,
                          input bit gaps);
    logic [ADDR_W-1:0] idx;
    int                n;
    idx = addr[ADDR_W+1:2];
    if (early_w) begin
      wvalid = 1'b1; wdata = $urandom; wstrb = 4'hF;
      @(negedge clk);
      check("wready_before_aw", {31'h0, wready}, 32'h0);
      @(posedge clk);
      #1;
      wvalid = 1'b0;
    end
    awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = 3'($urandom);
    awvalid = 1'b1;
    @(negedge clk);
    check("awready_idle", {31'h0, awready}, 32'h1);
    check("wready_idle", {31'h0, wready}, 32'h0);
    @(posedge clk);
    #1;
    awvalid = 1'b0;
    awaddr  = $urandom;
    for (int b = 0; b <= int'(len); b++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        wvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      wvalid = 1'b1;
      wdata  = wbuf_data[b];
      wstrb  = wbuf_strb[b];
      wid    = 4'($urandom);
      wlast  = gaps ? 1'($urandom) : (b == int'(len));
      @(negedge clk);
      check("wready_data", {31'h0, wready}, 32'h1);
      @(posedge clk);
      #1;
      model_write(idx, wbuf_data[b], wbuf_strb[b]);
      if (burst != 2'b00) idx = idx + 1'b1;
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    bq.push_back(id);
    bready = 1'b0;
    for (int h = 0; h < bhold; h++) begin
      @(negedge clk);
      check("bvalid_hold", {31'h0, bvalid}, 32'h1);
      check("awready_in_resp", {31'h0, awready}, 32'h0);
      @(posedge clk);
      #1;
    end
    bready = 1'b1;
    n = 0;
    while (bq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bq.size() != 0) begin
      check("b_timeout", 32'h0, 32'h1);
      bq.delete();
    end
    @(posedge clk);
    #1;
    bready = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_arready"}, {31'h0, arready}, 32'h1);
    check({tag, "_awready"}, {31'h0, awready}, 32'h1);
    check({tag, "_rvalid"}, {31'h0, rvalid}, 32'h0);
    check({tag, "_wready"}, {31'h0, wready}, 32'h0);
    check({tag, "_bvalid"}, {31'h0, bvalid}, 32'h0);
    check({tag, "_rlast"}, {31'h0, rlast}, 32'h0);
    check({tag, "_rid"}, {28'h0, rid}, 32'h0);
    check({tag, "_bid"}, {28'h0, bid}, 32'h0);
    check({tag, "_rresp"}, {30'h0, rresp}, 32'h0);
    check({tag, "_bresp"}, {30'h0, bresp}, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0]  len;
    logic [31:0] addr;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    reset = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    arlock = '0; arcache = '0; arprot = '0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    awlock = '0; awcache = '0; awprot = '0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;

    do_read(4'h1, 32'h0000_2000, 8'd1, 2'b01);

    wbuf_data[0] = 32'hDEADBEEF; wbuf_strb[0] = 4'hF;
    do_write(4'h5, 32'h0000_0010, 8'd0, 2'b01, 0, 1'b1, 1'b0);
    do_read(4'h3, 32'h0000_0010, 8'd0, 2'b01);

    for (int b = 0; b < 4; b++) begin wbuf_data[b] = b + 1; wbuf_strb[b] = 4'hF; end
    do_write(4'h9, 32'h0000_0100, 8'd3, 2'b01, 0, 1'b0, 1'b0);
    do_read(4'h7, 32'h0000_0100, 8'd3, 2'b01);

    wbuf_data[0] = 32'h11223344; wbuf_strb[0] = 4'hF;
    do_write(4'h2, 32'h0000_0040, 8'd0, 2'b01, 0, 1'b0, 1'b0);
    wbuf_data[0] = 32'hAABBCCDD; wbuf_strb[0] = 4'b0101;
    do_write(4'h2, 32'h0000_0040, 8'd0, 2'b01, 0, 1'b0, 1'b0);
    do_read(4'h4, 32'h0000_0040, 8'd0, 2'b01);

    rready_mode = 1;
    do_read(4'hA, 32'h0000_0100, 8'd3, 2'b01);
    rready_mode = 0;
    wbuf_data[0] = 32'hCAFE0001; wbuf_strb[0] = 4'hF;
    do_write(4'hB, 32'h0000_0300, 8'd0, 2'b01, 5, 1'b0, 1'b0);

    for (int b = 0; b < 4; b++) begin wbuf_data[b] = 32'h5A5A0000 + b; wbuf_strb[b] = 4'hF; end
    do_write(4'hC, {18'h0, 12'd4094, 2'b00}, 8'd3, 2'b10, 0, 1'b0, 1'b0);
    do_read(4'hC, {18'h0, 12'd4094, 2'b00}, 8'd3, 2'b01);
    wbuf_data[0] = 32'h000000A1; wbuf_strb[0] = 4'b0001;
    wbuf_data[1] = 32'h0000B200; wbuf_strb[1] = 4'b0010;
    wbuf_data[2] = 32'hFFFFFFFF; wbuf_strb[2] = 4'b1000;
    do_write(4'hD, 32'hFFFF_0500, 8'd2, 2'b00, 1, 1'b0, 1'b0);
    do_read(4'hD, 32'h0000_0500, 8'd2, 2'b00);

    for (int b = 0; b < 4; b++) begin wbuf_data[b] = 32'h0BAD0000 + b; wbuf_strb[b] = 4'hF; end
    do_write(4'h6, 32'h0000_0200, 8'd3, 2'b01, 0, 1'b0, 1'b0);
    awid = 4'hE; awaddr = 32'h0000_0200; awlen = 8'd3; awburst = 2'b01; awvalid = 1'b1;
    @(posedge clk);
    #1;
    awvalid = 1'b0;
    wvalid = 1'b1; wdata = 32'h12345678; wstrb = 4'hF;
    @(posedge clk);
    #1;
    model_write(12'h080, 32'h12345678, 4'hF);
    wdata = 32'h87654321;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    wvalid = 1'b0;
    @(negedge clk);
    check_idle_outputs("midburst_reset");
    reset = 1'b0;
    @(posedge clk);
    #1;
    do_read(4'h8, 32'h0000_0200, 8'd3, 2'b01);

    for (int t = 0; t < 40; t++) begin
      len  = 8'($urandom_range(0, 7));
      addr = (t % 8 == 0) ? {$urandom_range(0, 65535), 4'hF, 12'hFFC} | 32'h3 : $urandom;
      rready_mode = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 0) begin
        for (int b = 0; b <= int'(len); b++) begin
          wbuf_data[b] = $urandom;
          wbuf_strb[b] = 4'($urandom);
        end
        do_write(4'($urandom), addr, len, 2'($urandom_range(0, 2)),
                 $urandom_range(0, 3), 1'($urandom), 1'b1);
      end else begin
        do_read(4'($urandom), addr, len, 2'($urandom_range(0, 2)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
